external_interrupt_unit: RTL
============================

# external_interrupt_unit

Three-channel external interrupt source block that turns asynchronous pin inputs into clean one-cycle interrupt request pulses. Each channel synchronises its pin, rejects glitches with a debounce filter, and applies a per-channel sense mode: low level, any change, falling edge or rising edge. Its `interrupt_request_1..3` outputs drive the matching request inputs of the interrupt controller directly. Each pulse is one buffered request there.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a new pin level must hold before it is accepted; legal range 1..255.
- `LEVEL_REPEAT`, 64: in low-level mode, cycles between repeated request pulses while the pin stays low; legal range 2..65535.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ext_pin_1`, `ext_pin_2`, `ext_pin_3` in 1: asynchronous external pins; idle level is high (pull-up).
- `sense_mode_1`, `sense_mode_2`, `sense_mode_3` in 2: 00 low level, 01 any change, 10 falling, 11 rising. Quasi-static, from the configuration register.
- `channel_enable_1`, `channel_enable_2`, `channel_enable_3` in 1: gates request generation only.
- `interrupt_request_1`, `interrupt_request_2`, `interrupt_request_3` out 1: registered one-cycle request pulses.
- `pin_level_1`, `pin_level_2`, `pin_level_3` out 1: debounced (filtered) pin level, for status readback.

## Operation
- Reset values:
  - synchroniser flops = 1, filtered level = 1.
  - debounce and repeat counters = 0.
  - all `interrupt_request_*` = 0; all `pin_level_*` = 1.
- Synchroniser: two flops per pin. The filter sees only the second flop's output (`sync`).
- Debounce filter:
  - The counter increments each cycle that `sync` differs from `filtered` and clears on any cycle they match.
  - When the count reaches `DEBOUNCE_CYCLES`, `filtered` takes the value of `sync` and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach `filtered`.
- Edge detect: compare `filtered` with its previous-cycle copy (`filtered_d`).
- Request generation, evaluated each cycle and registered:
  - Rising mode: request when `filtered`=1 and `filtered_d`=0.
  - Falling mode: request when `filtered`=0 and `filtered_d`=1.
  - Any-change mode: request when `filtered`≠`filtered_d`.
  - Low-level mode: request when the repeat counter is 0 and `filtered`=0.
    - The counter then counts `LEVEL_REPEAT-1` down to 0 while `filtered` stays low, giving one pulse every `LEVEL_REPEAT` cycles.
    - The counter is forced to 0 when `filtered`=1, when the channel is disabled, or when the mode is not 00.
- Enable:
  - While `channel_enable`=0 the request is forced to 0; edges during that time are lost, not queued.
  - Synchroniser and filter keep running, so `pin_level` stays valid.
- Mode change: takes effect the next cycle. No pulse is generated by the mode change itself; only a real edge or level condition that cycle produces one.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- A pin held low through reset release gives a falling-edge request after the normal latency, because `filtered` resets to 1.

## Timing
- Reference point: the pin changes before clock edge E0 and is stable afterwards.
  - E0: sync1 captures the new level.
  - E1: `sync` shows the new level.
  - E(D+1): `filtered` updates, where D = `DEBOUNCE_CYCLES`.
  - E(D+2): the request rises, for exactly one cycle.
- With D=4 the request is high in the cycle after E6.
- `pin_level` follows `filtered`, so it updates at E(D+1).
- Low-level mode: the first pulse comes at E(D+2), then pulses repeat every `LEVEL_REPEAT` cycles.
- Enable rising while `filtered` is already low in mode 00: a pulse comes at the next edge.
- Asynchronous reset mid-operation: all state returns to reset values immediately, and any request pulse in flight is dropped.

## Structure
- Shared package `ext_int_pkg`:
  - `sense_mode_t` enum: `SENSE_LOW`=2'b00, `SENSE_ANY`=2'b01, `SENSE_FALL`=2'b10, `SENSE_RISE`=2'b11.
  - Counter width helper functions based on `$clog2`.
- Sub-module `ext_int_channel`: synchroniser, debounce filter, edge detect, repeat counter and request register for one pin.
- The top instantiates it three times and maps the numbered ports.

## Test plan
- Rising mode, D=4, enabled, pin 0→1 held: `interrupt_request_1` high for exactly one cycle after E6, `pin_level_1`=1 from E5; no pulse on the later 1→0.
- Falling mode, 3-cycle low glitch with D=4: no request, `pin_level` stays 1; a 6-cycle low pulse gives one request.
- Low-level mode, `LEVEL_REPEAT`=8, pin low for 30 cycles after debounce: 4 pulses spaced exactly 8 cycles apart, and no further pulses after the pin returns high.
- Any-change mode with channel 2 disabled during a 0→1 edge, then enabled: no request for that edge; the next 1→0 edge produces one pulse.
- All three channels get an edge in the same cycle in their matching modes: three simultaneous pulses.
- `rst_n` asserted 2 cycles into a debounce window: outputs return to 0/1 immediately; a pin held low through reset release gives one falling-edge request at E(D+2) after release.

Source files
------------

// File: rtl/ext_int_pkg.sv
// Shared types and sizing helpers for the external interrupt unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ext_int_pkg;

  typedef enum logic [1:0] {
    SENSE_LOW  = 2'b00,
    SENSE_ANY  = 2'b01,
    SENSE_FALL = 2'b10,
    SENSE_RISE = 2'b11
  } sense_mode_t;

  // Bits needed to hold any value in 0..max_count (never less than one bit).
  function automatic int unsigned count_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/ext_int_channel.sv
// One external interrupt channel: 2-flop synchroniser, debounce, edge/level sense, request register.
// Latency: request rises DEBOUNCE_CYCLES+2 edges after the pin change is first captured.
// Backpressure: none; requests are one-cycle pulses, edges seen while disabled are dropped.
module ext_int_channel
  import ext_int_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LEVEL_REPEAT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_pin,
  input  logic [1:0] sense_mode,
  input  logic       channel_enable,
  output logic       interrupt_request,
  output logic       pin_level
);

  localparam int unsigned DB_W = count_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned RP_W = count_width(LEVEL_REPEAT - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LOAD = RP_W'(LEVEL_REPEAT - 1);

  sense_mode_t     mode;
  logic            sync1;
  logic            sync;
  logic            filtered;
  logic            filtered_d;
  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rep_cnt;
  logic            low_active;
  logic            req_next;

  assign mode      = sense_mode_t'(sense_mode);
  assign pin_level = filtered;

  // Two-flop synchroniser; idle-high so flops reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync  <= 1'b1;
    end else begin
      sync1 <= ext_pin;
      sync  <= sync1;
    end
  end

  // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtered <= 1'b1;
      db_cnt   <= '0;
    end else if (sync == filtered) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      filtered <= sync;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Previous-cycle copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filtered_d <= 1'b1;
    else        filtered_d <= filtered;
  end

  // Next request from the sense mode; the low-level case fires whenever the repeat counter is idle.
  always_comb begin
    req_next   = 1'b0;
    low_active = channel_enable && (mode == SENSE_LOW) && !filtered;
    unique case (mode)
      SENSE_LOW:  req_next = low_active && (rep_cnt == '0);
      SENSE_ANY:  req_next = filtered != filtered_d;
      SENSE_FALL: req_next = !filtered && filtered_d;
      SENSE_RISE: req_next = filtered && !filtered_d;
    endcase
    if (!channel_enable) req_next = 1'b0;
  end

  // Repeat counter: reload after each low-level pulse, count down while the level condition holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rep_cnt <= '0;
    else if (!low_active)      rep_cnt <= '0;
    else if (rep_cnt == '0)    rep_cnt <= RP_LOAD;
    else                       rep_cnt <= rep_cnt - 1'b1;
  end

  // Registered one-cycle request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) interrupt_request <= 1'b0;
    else        interrupt_request <= req_next;
  end

endmodule

// File: rtl/external_interrupt_unit.sv
// Three independent external interrupt channels feeding the interrupt controller request inputs.
// Latency: DEBOUNCE_CYCLES+2 edges from pin capture to request pulse.
// Backpressure: none; each pulse is buffered by the interrupt controller.
module external_interrupt_unit
  import ext_int_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LEVEL_REPEAT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_pin_1,
  input  logic       ext_pin_2,
  input  logic       ext_pin_3,
  input  logic [1:0] sense_mode_1,
  input  logic [1:0] sense_mode_2,
  input  logic [1:0] sense_mode_3,
  input  logic       channel_enable_1,
  input  logic       channel_enable_2,
  input  logic       channel_enable_3,
  output logic       interrupt_request_1,
  output logic       interrupt_request_2,
  output logic       interrupt_request_3,
  output logic       pin_level_1,
  output logic       pin_level_2,
  output logic       pin_level_3
);

  ext_int_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LEVEL_REPEAT(LEVEL_REPEAT)) u_ch1 (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_pin           (ext_pin_1),
    .sense_mode        (sense_mode_1),
    .channel_enable    (channel_enable_1),
    .interrupt_request (interrupt_request_1),
    .pin_level         (pin_level_1)
  );

  ext_int_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LEVEL_REPEAT(LEVEL_REPEAT)) u_ch2 (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_pin           (ext_pin_2),
    .sense_mode        (sense_mode_2),
    .channel_enable    (channel_enable_2),
    .interrupt_request (interrupt_request_2),
    .pin_level         (pin_level_2)
  );

  ext_int_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LEVEL_REPEAT(LEVEL_REPEAT)) u_ch3 (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_pin           (ext_pin_3),
    .sense_mode        (sense_mode_3),
    .channel_enable    (channel_enable_3),
    .interrupt_request (interrupt_request_3),
    .pin_level         (pin_level_3)
  );

endmodule
